// File: rtl/b_mcp_pkg.sv
// Shared definitions for the multi-channel receive block: per-channel state
// encoding and the supported parameter ranges.
package b_mcp_pkg;

  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } b_mcp_state_e;

  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 16;
  localparam int DW_MIN  = 1;
  localparam int DW_MAX  = 64;

endpackage

// File: rtl/b_mcp_chan.sv
// One receive channel: WAIT/READY handshake FSM, captured data register,
// acknowledge toggle back to the sender and a sticky overrun flag.
module b_mcp_chan
  import b_mcp_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          back_o,
  output logic          err_o,
  output logic          accept_o
);

  b_mcp_state_e  state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          back_q, back_d;
  logic          err_q, err_d;
  logic          accept_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT;
      data_q  <= {DW{1'b0}};
      back_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      back_q  <= back_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    back_d   = back_q;
    err_d    = err_q;
    accept_s = 1'b0;
    case (state_q)
      WAIT: begin
        if (en_i) begin
          state_d = READY;
          data_d  = data_i;
        end else begin
          state_d = WAIT;
        end
      end
      READY: begin
        if (load_i) begin
          accept_s = 1'b1;
          back_d   = ~back_q;
          // A fresh pulse alongside the load refills the slot immediately.
          if (en_i) begin
            data_d  = data_i;
            state_d = READY;
          end else begin
            state_d = WAIT;
          end
        end else if (en_i) begin
          err_d = 1'b1;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  assign valid_o  = (state_q == READY);
  assign data_o   = data_q;
  assign back_o   = back_q;
  assign err_o    = err_q;
  assign accept_o = accept_s;

endmodule

// File: rtl/b_mcp_rx.sv
// Multi-channel receive side of a mux-based clock-domain crossing: NCH
// independent channels plus a shared counter of accepted loads.
module b_mcp_rx
  import b_mcp_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic              bclk,
  input  logic              brst,
  input  logic [NCH-1:0]    b_en,
  input  logic [NCH*DW-1:0] adata,
  input  logic [NCH-1:0]    bload,
  output logic [NCH-1:0]    bvalid,
  output logic [NCH*DW-1:0] bdata,
  output logic [NCH-1:0]    back,
  output logic [NCH-1:0]    berr,
  output logic [CNTW-1:0]   bcount
);

  logic [NCH-1:0]  accept_s;
  logic [CNTW-1:0] bcount_q, bcount_d;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    b_mcp_chan #(
      .DW(DW)
    ) u_chan (
      .clk_i   (bclk),
      .rst_i   (brst),
      .en_i    (b_en[gi]),
      .load_i  (bload[gi]),
      .data_i  (adata[gi*DW +: DW]),
      .valid_o (bvalid[gi]),
      .data_o  (bdata[gi*DW +: DW]),
      .back_o  (back[gi]),
      .err_o   (berr[gi]),
      .accept_o(accept_s[gi])
    );
  end

  // Sum is taken modulo 2^CNTW, so the counter wraps naturally.
  always_comb begin
    bcount_d = bcount_q;
    for (int i = 0; i < NCH; i++) begin
      bcount_d = bcount_d + CNTW'(accept_s[i]);
    end
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      bcount_q <= {CNTW{1'b0}};
    end else begin
      bcount_q <= bcount_d;
    end
  end

  assign bcount = bcount_q;

endmodule

// File: tb/tb_b_mcp_rx.sv
// Directed scoreboard bench for b_mcp_rx (NCH=4, DW=8, CNTW=4 so the counter
// wrap is reachable): stimulus pushes hand-computed expectations, a monitor pops.
module tb_b_mcp_rx;

  logic        bclk;
  logic        brst;
  logic [3:0]  b_en;
  logic [31:0] adata;
  logic [3:0]  bload;
  logic [3:0]  bvalid;
  logic [31:0] bdata;
  logic [3:0]  back;
  logic [3:0]  berr;
  logic [3:0]  bcount;

  typedef struct {
    string       nm;
    logic [3:0]  v;
    logic [3:0]  bk;
    logic [3:0]  er;
    logic [31:0] d;
    logic [3:0]  c;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  b_mcp_rx #(
    .NCH (4),
    .DW  (8),
    .CNTW(4)
  ) dut (
    .bclk  (bclk),
    .brst  (brst),
    .b_en  (b_en),
    .adata (adata),
    .bload (bload),
    .bvalid(bvalid),
    .bdata (bdata),
    .back  (back),
    .berr  (berr),
    .bcount(bcount)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
    end
  endfunction

  // Monitor: outputs are registered, so sample mid-cycle against the queue head.
  always @(negedge bclk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.nm, "bvalid", 32'(bvalid), 32'(e.v));
      chk(e.nm, "back",   32'(back),   32'(e.bk));
      chk(e.nm, "berr",   32'(berr),   32'(e.er));
      chk(e.nm, "bdata",  bdata,       e.d);
      chk(e.nm, "bcount", 32'(bcount), 32'(e.c));
    end
  end

  task automatic step(input string nm, input logic rst, input logic [3:0] en,
                      input logic [3:0] ld, input logic [31:0] ad,
                      input logic [3:0] v, input logic [3:0] bk, input logic [3:0] er,
                      input logic [31:0] d, input logic [3:0] c);
    exp_t e;
    @(negedge bclk);
    brst  = rst;
    b_en  = en;
    bload = ld;
    adata = ad;
    @(posedge bclk);
    #1;
    e.nm = nm; e.v = v; e.bk = bk; e.er = er; e.d = d; e.c = c;
    sb_q.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    brst  = 1'b1;
    b_en  = 4'b0000;
    bload = 4'b0000;
    adata = 32'h0000_0000;
    //   name         rst   en       ld       adata          bvalid   back     berr     bdata          bcount
    step("reset",     1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'd0);
    step("en0",       1'b0, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, 4'b0000, 4'b0000, 32'h0000_00A5, 4'd0);
    step("hold0",     1'b0, 4'b0000, 4'b0000, 32'h0000_00FF, 4'b0001, 4'b0000, 4'b0000, 32'h0000_00A5, 4'd0);
    step("load0",     1'b0, 4'b0000, 4'b0001, 32'h0000_00FF, 4'b0000, 4'b0001, 4'b0000, 32'h0000_00A5, 4'd1);
    step("ld_wait0",  1'b0, 4'b0000, 4'b0001, 32'h0000_00FF, 4'b0000, 4'b0001, 4'b0000, 32'h0000_00A5, 4'd1);
    step("en1",       1'b0, 4'b0010, 4'b0000, 32'h0000_1100, 4'b0010, 4'b0001, 4'b0000, 32'h0000_11A5, 4'd1);
    step("hold1",     1'b0, 4'b0000, 4'b0000, 32'h0000_2200, 4'b0010, 4'b0001, 4'b0000, 32'h0000_11A5, 4'd1);
    step("en2",       1'b0, 4'b0100, 4'b0000, 32'h0033_0000, 4'b0110, 4'b0001, 4'b0000, 32'h0033_11A5, 4'd1);
    step("ovr2",      1'b0, 4'b0100, 4'b0000, 32'h0044_0000, 4'b0110, 4'b0001, 4'b0100, 32'h0033_11A5, 4'd1);
    step("en0_3",     1'b0, 4'b1001, 4'b0000, 32'h5500_0066, 4'b1111, 4'b0001, 4'b0100, 32'h5533_1166, 4'd1);
    step("load_all",  1'b0, 4'b0000, 4'b1111, 32'h0000_0000, 4'b0000, 4'b1110, 4'b0100, 32'h5533_1166, 4'd5);
    step("en_all",    1'b0, 4'b1111, 4'b0000, 32'h0A0B_0C0D, 4'b1111, 4'b1110, 4'b0100, 32'h0A0B_0C0D, 4'd5);
    step("both_a",    1'b0, 4'b1111, 4'b1111, 32'h0102_0304, 4'b1111, 4'b0001, 4'b0100, 32'h0102_0304, 4'd9);
    step("both_b",    1'b0, 4'b1111, 4'b1111, 32'h0506_0708, 4'b1111, 4'b1110, 4'b0100, 32'h0506_0708, 4'd13);
    step("both3",     1'b0, 4'b1000, 4'b1000, 32'h3C00_0000, 4'b1111, 4'b0110, 4'b0100, 32'h3C06_0708, 4'd14);
    step("wrap",      1'b0, 4'b0000, 4'b1111, 32'h0000_0000, 4'b0000, 4'b1001, 4'b0100, 32'h3C06_0708, 4'd2);
    step("en0b",      1'b0, 4'b0001, 4'b0000, 32'h0000_00B7, 4'b0001, 4'b1001, 4'b0100, 32'h3C06_07B7, 4'd2);
    step("rst_ld",    1'b1, 4'b0000, 4'b0001, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'd0);
    step("post_rst",  1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'd0);
    @(negedge bclk);
    b_en  = 4'b0000;
    bload = 4'b0000;
    for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
      @(posedge bclk);
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b_mcp_rx.md
B_MCP_RX -- requirements
Module: b_mcp_rx

Interface
REQ-001 Parameter NCH, default 4: number of independent receive channels (1..16).
REQ-002 Parameter DW, default 8: data width per channel (1..64).
REQ-003 Parameter CNTW, default 16: width of the accepted-transfer counter.
REQ-004 bclk  input  1  receive-domain clock; all logic on its rising edge.
REQ-005 brst  input  1  reset, synchronous, active-high.
REQ-006 b_en  input  NCH  per-channel single-cycle pulse, already synchronised into bclk; means "adata for this channel is stable".
REQ-007 adata  input  NCH*DW  per-channel data from the sending domain; channel i occupies bits [i*DW +: DW].
REQ-008 bload  input  NCH  per-channel consumer load strobe / acknowledge request.
REQ-009 bvalid  output  NCH  per-channel data valid / ready to load.
REQ-010 bdata  output  NCH*DW  per-channel captured data, same packing as adata.
REQ-011 back  output  NCH  per-channel acknowledge toggle returned to the sending domain.
REQ-012 berr  output  NCH  per-channel sticky overrun flag.
REQ-013 bcount  output  CNTW  total accepted loads across all channels.

Function
REQ-014 Each channel shall run an independent two-state FSM: WAIT (bvalid=0) and READY (bvalid=1).
REQ-015 WAIT -> READY on b_en[i]=1; on that edge adata[i] shall be registered into bdata[i]; bvalid[i] shall be 1 on the next cycle (latency 1).
REQ-016 WAIT with b_en[i]=0 shall remain WAIT; bdata[i] shall hold.
REQ-017 READY -> WAIT on bload[i]=1; on that edge back[i] shall invert; bvalid[i] shall be 0 on the next cycle.
REQ-018 READY with bload[i]=0 shall remain READY; bdata[i] shall hold, not follow adata.
REQ-019 bload[i] in WAIT shall be ignored: no state change, no back toggle, no count.
REQ-020 b_en[i] in READY without bload[i] shall be an overrun: berr[i] shall set on the next cycle and stay set until reset; state and bdata[i] shall be unchanged.
REQ-021 b_en[i] and bload[i] together in READY: load accepted (back toggles, count increments), the new data captured, and the state shall stay READY; berr[i] shall not set.
REQ-022 bcount shall add the number of channels whose load is accepted in the cycle (0..NCH), and wrap modulo 2^CNTW.
REQ-023 Channels shall not interact except through bcount.

Reset
REQ-024 With brst=1 at a rising bclk edge, every channel shall enter WAIT; bvalid=0, bdata=0, back=0, berr=0, bcount=0 from the next cycle.
REQ-025 Reset mid-transfer (READY, unloaded) shall discard the data without toggling back.
REQ-026 brst shall take priority over b_en and bload in the same cycle.

Structure
REQ-027 Package b_mcp_pkg shall hold the state enum (WAIT='0, READY='1) and the parameter limit constants.
REQ-028 Sub-module b_mcp_chan shall implement one channel: FSM, data register, back toggle, berr; instantiated NCH times by a generate loop.
REQ-029 The top level shall hold only the generate loop, the accepted-load popcount and the bcount register.
REQ-030 bvalid shall be decoded directly from the state register, with no combinational path from inputs to outputs.

Verification
REQ-031 NCH=4, DW=8: reset, b_en[0] pulse with adata[0]=8'hA5 -> cycle+1 bvalid[0]=1, bdata[0]=8'hA5; bload[0] -> back[0] 0->1, bvalid[0]=0, bcount=1.
REQ-032 READY ch1, adata[1] changes 8'h11->8'h22 without b_en -> bdata[1] stays 8'h11.
REQ-033 READY ch2, second b_en pulse without bload -> berr[2]=1 sticky, bdata[2] unchanged; other berr bits 0.
REQ-034 All four channels READY, bload=4'b1111 in one cycle -> bcount +4, all back bits toggle; CNTW=4 with bcount=14 -> wraps to 2.
REQ-035 ch3 READY, b_en and bload same cycle with adata[3]=8'h3C -> stays READY, bdata[3]=8'h3C, back[3] toggles, berr[3]=0.
REQ-036 brst asserted while ch0 READY and bload[0]=1 -> next cycle WAIT, back[0]=0, bcount=0.
